tx_arbiter: RTL
===============

TX_ARBITER -- requirements
Module: tx_arbiter

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per client FIFO (power of 2, >= 2).
REQ-002 SHALL have port clk  input  1  system clock; all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port c0_data  input  8  client 0 write byte.
REQ-005 SHALL have port c0_wr  input  1  client 0 write strobe, one byte per cycle high.
REQ-006 SHALL have port c0_full  output  1  client 0 FIFO holds DEPTH entries.
REQ-007 SHALL have port c0_ovf  output  1  sticky flag: client 0 wrote while full.
REQ-008 SHALL have ports c1_data, c1_wr, c1_full, c1_ovf, identical to REQ-004..007 for client 1.
REQ-009 SHALL have port tx_char  output  8  byte presented to the serial transmitter.
REQ-010 SHALL have port tx_send  output  1  one-cycle send request to the transmitter.
REQ-011 SHALL have port tx_busy  input  1  transmitter busy; low only when it is idle.
REQ-012 SHALL have port grant  output  1  client index of the byte issued or in flight.
REQ-013 SHALL have port idle  output  1  high when both FIFOs are empty and FSM is in S_IDLE.

Function
REQ-014 SHALL implement per client a DEPTH-entry FIFO with wrapping read/write pointers and a count register of width log2(DEPTH)+1.
REQ-015 SHALL accept a write when cN_wr=1 and cN_full=0; the byte is visible to the arbiter on the next cycle.
REQ-016 SHALL drop a write when cN_wr=1 and cN_full=1, leave the FIFO unchanged, and set cN_ovf=1 until rst.
REQ-017 SHALL base cN_full on the registered count; a pop in the same cycle does not admit a write while full.
REQ-018 SHALL allow a simultaneous write and pop on a non-full FIFO, with count unchanged.
REQ-019 SHALL implement FSM states S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE.
REQ-020 SHALL in S_IDLE, when at least one FIFO is non-empty and tx_busy=0, do all of the following in one cycle: select a client, load tx_char from that FIFO head, pop it, update grant, and move to S_ISSUE.
REQ-021 SHALL arbitrate round-robin: if both FIFOs are non-empty, the client not granted last wins; if only one is non-empty, that client wins.
REQ-022 SHALL remain in S_IDLE with tx_send=0 while tx_busy=1 or both FIFOs are empty.
REQ-023 SHALL drive tx_send=1 only in S_ISSUE, for exactly one cycle, then move to S_WAIT_BUSY.
REQ-024 SHALL in S_WAIT_BUSY move to S_WAIT_DONE on the first cycle tx_busy=1.
REQ-025 SHALL in S_WAIT_DONE move to S_IDLE on the first cycle tx_busy=0.
REQ-026 SHALL hold tx_char and grant stable from S_ISSUE until the next grant.
REQ-027 SHALL give latency from cN_wr (empty FIFO, S_IDLE, tx_busy=0) at cycle N to tx_send=1 at cycle N+2.
REQ-028 SHALL issue bytes of one client in write order, with no byte lost or duplicated unless dropped per REQ-016.
REQ-029 SHALL keep at most one byte outstanding at the transmitter.

Reset
REQ-030 SHALL on rst set state S_IDLE, both FIFO counts and pointers to 0, cN_full=0, cN_ovf=0, tx_send=0, tx_char=8'h00, grant=0, idle=1, and last-granted=1 so client 0 wins the first tie.
REQ-031 SHALL on rst mid-transfer flush all queued bytes and reissue nothing; the transmitter shares the same rst.
REQ-032 SHALL ignore cN_wr in any cycle where rst=1.

Verification
REQ-033 SHALL pass: after reset, c0 writes 8'h41 at cycle N, tx_busy=0 -> tx_send=1 and tx_char=8'h41 at N+2, grant=0.
REQ-034 SHALL pass: both FIFOs preloaded with 3 bytes (c0 A0..A2, c1 B0..B2), transmitter model busy for 10 cycles per byte -> issue order A0,B0,A1,B1,A2,B2.
REQ-035 SHALL pass: c1 writes 5 bytes back-to-back with DEPTH=4 and tx_busy held at 1 -> c1_full=1 after 4 writes, 5th dropped, c1_ovf=1, 4 bytes later issued in order.
REQ-036 SHALL pass: c0 FIFO full with a pop and write in the same cycle -> write dropped, c0_ovf=1, count=3.
REQ-037 SHALL pass: rst asserted in S_WAIT_DONE with 2 bytes queued -> next cycle idle=1 and counts=0; no tx_send occurs after rst releases until a new write.

Source files
------------

// File: rtl/tx_arbiter.sv
// Two-client byte arbiter: per-client FIFOs feeding one serial transmitter, round-robin on ties.
// state       | meaning
// S_IDLE      | waiting for a queued byte and an idle transmitter
// S_ISSUE     | tx_send pulse for the byte just loaded
// S_WAIT_BUSY | waiting for the transmitter to take the byte
// S_WAIT_DONE | waiting for the transmitter to finish
module tx_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] c0_data,
    input  logic       c0_wr,
    output logic       c0_full,
    output logic       c0_ovf,
    input  logic [7:0] c1_data,
    input  logic       c1_wr,
    output logic       c1_full,
    output logic       c1_ovf,
    output logic [7:0] tx_char,
    output logic       tx_send,
    input  logic       tx_busy,
    output logic       grant,
    output logic       idle
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW-1:0] PTR_ONE  = 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT_BUSY, S_WAIT_DONE} state_t;

    state_t        state_q, state_d;
    logic [7:0]    mem_q [2][DEPTH];
    logic [AW-1:0] wp_q [2];
    logic [AW-1:0] wp_d [2];
    logic [AW-1:0] rp_q [2];
    logic [AW-1:0] rp_d [2];
    logic [AW:0]   cnt_q [2];
    logic [AW:0]   cnt_d [2];
    logic [1:0]    ovf_q, ovf_d;
    logic [7:0]    tx_char_q, tx_char_d;
    logic          tx_send_q, tx_send_d;
    logic          grant_q, grant_d;
    logic          last_q, last_d;

    logic [1:0]    wr, full, nonempty, push, pop;
    logic [7:0]    wdata [2];
    logic          sel;

    assign wr       = {c1_wr, c0_wr};
    assign wdata[0] = c0_data;
    assign wdata[1] = c1_data;

    always_comb begin
        state_d   = state_q;
        tx_char_d = tx_char_q;
        tx_send_d = 1'b0;
        grant_d   = grant_q;
        last_d    = last_q;
        ovf_d     = ovf_q;
        pop       = 2'b00;
        sel       = 1'b0;
        for (int c = 0; c < 2; c++) begin
            full[c]     = (cnt_q[c] == FULL_CNT);
            nonempty[c] = (cnt_q[c] != '0);
        end

        case (state_q)
            S_IDLE: begin
                if (!tx_busy && (nonempty != 2'b00)) begin
                    // On a tie the client not served last goes next.
                    sel       = (nonempty == 2'b11) ? ~last_q : nonempty[1];
                    pop[sel]  = 1'b1;
                    tx_char_d = mem_q[sel][rp_q[sel]];
                    grant_d   = sel;
                    last_d    = sel;
                    tx_send_d = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE:     state_d = S_WAIT_BUSY;
            S_WAIT_BUSY: if (tx_busy)  state_d = S_WAIT_DONE;
            S_WAIT_DONE: if (!tx_busy) state_d = S_IDLE;
            default:     state_d = S_IDLE;
        endcase

        // Full comes from the registered count, so a same-cycle pop never frees a slot.
        for (int c = 0; c < 2; c++) begin
            push[c]  = wr[c] && !full[c];
            wp_d[c]  = push[c] ? wp_q[c] + PTR_ONE : wp_q[c];
            rp_d[c]  = pop[c]  ? rp_q[c] + PTR_ONE : rp_q[c];
            cnt_d[c] = cnt_q[c];
            if (push[c] && !pop[c]) cnt_d[c] = cnt_q[c] + CNT_ONE;
            if (!push[c] && pop[c]) cnt_d[c] = cnt_q[c] - CNT_ONE;
            if (wr[c] && full[c])   ovf_d[c] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            tx_char_q <= 8'h00;
            tx_send_q <= 1'b0;
            grant_q   <= 1'b0;
            last_q    <= 1'b1;
            ovf_q     <= 2'b00;
            for (int c = 0; c < 2; c++) begin
                wp_q[c]  <= '0;
                rp_q[c]  <= '0;
                cnt_q[c] <= '0;
            end
        end else begin
            state_q   <= state_d;
            tx_char_q <= tx_char_d;
            tx_send_q <= tx_send_d;
            grant_q   <= grant_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
            for (int c = 0; c < 2; c++) begin
                wp_q[c]  <= wp_d[c];
                rp_q[c]  <= rp_d[c];
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int c = 0; c < 2; c++) begin
            if (!rst && push[c]) mem_q[c][wp_q[c]] <= wdata[c];
        end
    end

    assign c0_full = full[0];
    assign c1_full = full[1];
    assign c0_ovf  = ovf_q[0];
    assign c1_ovf  = ovf_q[1];
    assign tx_char = tx_char_q;
    assign tx_send = tx_send_q;
    assign grant   = grant_q;
    assign idle    = (state_q == S_IDLE) && (nonempty == 2'b00);

endmodule
